// File: rtl/playfield_renderer.sv
// rtl/playfield_renderer.sv - wall bitmap plus sprite frame renderer for the VGA pixel port
//
// Purpose: on a start request, emits one pixel per clock. It first scans the
// COLS x ROWS wall bitmap column-major, then draws every enabled sprite in
// index order. Off-playfield sprite pixels still use a cycle but are not
// plotted. A start/busy/done handshake wraps each frame.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               frame request, sampled only while o_busy=0
//   o_busy, o_done        frame in progress / one-cycle end-of-frame pulse
//   o_mem_addr            bitmap address col*ROWS+row (registered)
//   i_mem_rdata           bitmap bit, valid one cycle after o_mem_addr
//   i_spr_en/_x/_y/_colour  per-sprite enable, top-left cell and colour (packed)
//   o_x, o_y, o_colour    screen pixel coordinate and colour (registered)
//   o_plot                write strobe for o_x/o_y/o_colour
module playfield_renderer #(
  parameter int COLS     = 120,
  parameter int ROWS     = 100,
  parameter int X_OFF    = 20,
  parameter int Y_OFF    = 10,
  parameter int NSPR     = 2,
  parameter int SPR_W    = 4,
  parameter int SPR_H    = 6,
  parameter int COORD_W  = 8,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] WALL_COLOUR = {COLOUR_W{1'b1}},
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = {COLOUR_W{1'b0}},
  parameter int ADDR_W   = $clog2(COLS*ROWS)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ADDR_W-1:0]          o_mem_addr,
  input  logic                       i_mem_rdata,
  input  logic [NSPR-1:0]            i_spr_en,
  input  logic [NSPR*COORD_W-1:0]    i_spr_x,
  input  logic [NSPR*COORD_W-1:0]    i_spr_y,
  input  logic [NSPR*COLOUR_W-1:0]   i_spr_colour,
  output logic [COORD_W-1:0]         o_x,
  output logic [COORD_W-1:0]         o_y,
  output logic [COLOUR_W-1:0]        o_colour,
  output logic                       o_plot
);

  localparam int SI_W = (NSPR > 1) ? $clog2(NSPR) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FIELD, S_SPRITE, S_DONE} state_t;

  state_t r_state, w_next;

  // Frame-start snapshot of the sprite inputs
  logic [NSPR-1:0]          r_en;
  logic [NSPR*COORD_W-1:0]  r_sx, r_sy;
  logic [NSPR*COLOUR_W-1:0] r_scol;

  // Scan counters: field cell and sprite pixel being fetched this cycle
  logic [COORD_W-1:0] r_col, r_row, r_c, r_r;
  logic [SI_W-1:0]    r_si;
  logic               r_spr_act;   // r_si names a sprite still being drawn
  logic               r_drain;     // second of the two pipeline drain cycles
  logic [ADDR_W-1:0]  r_mem_addr;

  // Stage 1 of the pixel pipeline, lined up with the memory read latency
  logic                r_p1_valid, r_p1_field, r_p1_plot;
  logic [COORD_W-1:0]  r_p1_x, r_p1_y;
  logic [COLOUR_W-1:0] r_p1_colour;

  logic                w_field_last, w_spr_last;
  logic                w_first_found, w_next_found;
  logic [SI_W-1:0]     w_first_idx, w_next_idx;
  logic [COORD_W-1:0]  w_sx, w_sy;
  logic [COLOUR_W-1:0] w_scol;
  logic [COORD_W:0]    w_px, w_py;   // one extra bit so sx+c cannot wrap

  assign w_field_last = (r_col == COORD_W'(COLS-1)) && (r_row == COORD_W'(ROWS-1));
  assign w_spr_last   = (r_c == COORD_W'(SPR_W-1)) && (r_r == COORD_W'(SPR_H-1));

  // Lowest enabled sprite overall, and lowest enabled sprite after r_si.
  // Descending loops so the lowest index is the last one written.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    for (int i = NSPR-1; i >= 0; i--) begin
      if (r_en[i]) begin
        w_first_found = 1'b1;
        w_first_idx   = SI_W'(i);
      end
      if (r_en[i] && (SI_W'(i) > r_si)) begin
        w_next_found = 1'b1;
        w_next_idx   = SI_W'(i);
      end
    end
  end

  always_comb begin
    w_sx   = '0;
    w_sy   = '0;
    w_scol = '0;
    for (int i = 0; i < NSPR; i++) begin
      if (r_si == SI_W'(i)) begin
        w_sx   = r_sx[i*COORD_W +: COORD_W];
        w_sy   = r_sy[i*COORD_W +: COORD_W];
        w_scol = r_scol[i*COLOUR_W +: COLOUR_W];
      end
    end
    w_px = {1'b0, w_sx} + {1'b0, r_c};
    w_py = {1'b0, w_sy} + {1'b0, r_r};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // SPRITE also covers two drain cycles so the last fetched pixel reaches
  // the output registers before DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_FIELD;
      S_FIELD:  if (w_field_last) w_next = S_SPRITE;
      S_SPRITE: if (!r_spr_act && r_drain) w_next = S_DONE;
      S_DONE:   w_next = i_start ? S_FIELD : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign o_busy     = (r_state == S_FIELD) || (r_state == S_SPRITE);
  assign o_done     = (r_state == S_DONE);
  assign o_mem_addr = r_mem_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_en <= '0; r_sx <= '0; r_sy <= '0; r_scol <= '0;
      r_col <= '0; r_row <= '0; r_c <= '0; r_r <= '0; r_si <= '0;
      r_spr_act <= 1'b0; r_drain <= 1'b0; r_mem_addr <= '0;
      r_p1_valid <= 1'b0; r_p1_field <= 1'b0; r_p1_plot <= 1'b0;
      r_p1_x <= '0; r_p1_y <= '0; r_p1_colour <= '0;
      o_x <= '0; o_y <= '0; o_colour <= '0; o_plot <= 1'b0;
    end else begin
      r_p1_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_en <= i_spr_en; r_sx <= i_spr_x; r_sy <= i_spr_y; r_scol <= i_spr_colour;
            r_col <= '0; r_row <= '0; r_mem_addr <= '0;
          end
        end
        S_FIELD: begin
          r_p1_valid <= 1'b1;
          r_p1_field <= 1'b1;
          r_p1_plot  <= 1'b1;
          r_p1_x     <= COORD_W'(X_OFF) + r_col;
          r_p1_y     <= COORD_W'(Y_OFF) + r_row;
          if (w_field_last) begin
            r_spr_act <= w_first_found;
            r_si      <= w_first_idx;
            r_c       <= '0;
            r_r       <= '0;
            r_drain   <= 1'b0;
          end else begin
            r_mem_addr <= r_mem_addr + ADDR_W'(1);
            if (r_row == COORD_W'(ROWS-1)) begin
              r_row <= '0;
              r_col <= r_col + COORD_W'(1);
            end else begin
              r_row <= r_row + COORD_W'(1);
            end
          end
        end
        S_SPRITE: begin
          if (r_spr_act) begin
            r_p1_valid  <= 1'b1;
            r_p1_field  <= 1'b0;
            r_p1_plot   <= (w_px < (COORD_W+1)'(COLS)) && (w_py < (COORD_W+1)'(ROWS));
            r_p1_x      <= COORD_W'(X_OFF) + w_px[COORD_W-1:0];
            r_p1_y      <= COORD_W'(Y_OFF) + w_py[COORD_W-1:0];
            r_p1_colour <= w_scol;
            if (w_spr_last) begin
              r_c       <= '0;
              r_r       <= '0;
              r_si      <= w_next_idx;
              r_spr_act <= w_next_found;
            end else if (r_r == COORD_W'(SPR_H-1)) begin
              r_r <= '0;
              r_c <= r_c + COORD_W'(1);
            end else begin
              r_r <= r_r + COORD_W'(1);
            end
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: ;
      endcase

      // Stage 2: wall colour comes straight from the memory read port
      o_plot <= r_p1_valid && r_p1_plot;
      if (r_p1_valid) begin
        o_x      <= r_p1_x;
        o_y      <= r_p1_y;
        o_colour <= r_p1_field ? (i_mem_rdata ? WALL_COLOUR : BG_COLOUR) : r_p1_colour;
      end
    end
  end

endmodule

// File: tb/tb_playfield_renderer.sv
// tb/tb_playfield_renderer.sv - self-checking bench for playfield_renderer
module tb_playfield_renderer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, plot;
  logic [5:0]  mem_addr;
  logic        mem_rdata = 1'b0;
  logic [1:0]  spr_en;
  logic [15:0] spr_x, spr_y;
  logic [5:0]  spr_colour;
  logic [7:0]  x, y;
  logic [2:0]  colour;

  int checks = 0;
  int failures = 0;

  int exp_plot [0:127];
  int exp_x    [0:127];
  int exp_y    [0:127];
  int exp_c    [0:127];
  int hits22   [$];

  typedef struct {
    int en;
    int sx0, sy0, c0;
    int sx1, sy1, c1;
    int disturb;
    int exp_done;
    int exp_plots;
  } frame_vec_t;

  frame_vec_t vecs [6];

  playfield_renderer #(
    .COLS(8), .ROWS(6), .X_OFF(20), .Y_OFF(10), .NSPR(2),
    .SPR_W(2), .SPR_H(2), .COORD_W(8), .COLOUR_W(3)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_busy(busy), .o_done(done), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .i_spr_en(spr_en), .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_colour(spr_colour),
    .o_x(x), .o_y(y), .o_colour(colour), .o_plot(plot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem_addr[0];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic build_expected(input frame_vec_t v);
    int e;
    int sx, sy, sc, px, py;
    for (int i = 0; i < 128; i++) begin
      exp_plot[i] = 0; exp_x[i] = 0; exp_y[i] = 0; exp_c[i] = 0;
    end
    for (int n = 0; n < 48; n++) begin
      exp_plot[2+n] = 1;
      exp_x[2+n] = 20 + n / 6;
      exp_y[2+n] = 10 + n % 6;
      exp_c[2+n] = (n % 2 == 1) ? 7 : 0;
    end
    e = 50;
    for (int s = 0; s < 2; s++) begin
      if (((v.en >> s) & 1) == 1) begin
        sx = (s == 0) ? v.sx0 : v.sx1;
        sy = (s == 0) ? v.sy0 : v.sy1;
        sc = (s == 0) ? v.c0 : v.c1;
        for (int c = 0; c < 2; c++) begin
          for (int r = 0; r < 2; r++) begin
            px = sx + c;
            py = sy + r;
            exp_plot[e] = (px < 8 && py < 6) ? 1 : 0;
            exp_x[e] = (20 + px) % 256;
            exp_y[e] = (10 + py) % 256;
            exp_c[e] = sc;
            e++;
          end
        end
      end
    end
  endtask

  task automatic run_frame(input int vi, input frame_vec_t v);
    int ndone, done_edge, nplots;
    build_expected(v);
    hits22.delete();
    spr_en = 2'(v.en);
    spr_x = {8'(v.sx1), 8'(v.sx0)};
    spr_y = {8'(v.sy1), 8'(v.sy0)};
    spr_colour = {3'(v.c1), 3'(v.c0)};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d busy_at_accept", vi), int'(busy), 1);
    ndone = 0; done_edge = -1; nplots = 0;
    for (int e = 1; e <= 70; e++) begin
      tick();
      chk($sformatf("v%0d e%0d busy", vi, e), int'(busy), (e < v.exp_done) ? 1 : 0);
      chk($sformatf("v%0d e%0d plot", vi, e), int'(plot), exp_plot[e]);
      if (plot && exp_plot[e] == 1) begin
        chk($sformatf("v%0d e%0d x", vi, e), int'(x), exp_x[e]);
        chk($sformatf("v%0d e%0d y", vi, e), int'(y), exp_y[e]);
        chk($sformatf("v%0d e%0d colour", vi, e), int'(colour), exp_c[e]);
      end
      if (plot) begin
        nplots++;
        if (x == 8'd22 && y == 8'd12) hits22.push_back(int'(colour));
      end
      if (done) begin
        ndone++;
        done_edge = e;
      end
      if (v.disturb != 0 && e == 10) begin
        spr_x = 16'h0000;
        spr_en = 2'b11;
        start = 1'b1;
      end
      if (e == 11) start = 1'b0;
    end
    chk($sformatf("v%0d done_edge", vi), done_edge, v.exp_done);
    chk($sformatf("v%0d done_count", vi), ndone, 1);
    chk($sformatf("v%0d plot_count", vi), nplots, v.exp_plots);
  endtask

  initial begin
    int got;

    vecs[0] = '{0,   0, 0, 0,   0, 0, 0,   0, 50, 48};
    vecs[1] = '{1,   7, 5, 4,   0, 0, 0,   0, 54, 49};
    vecs[2] = '{3,   1, 1, 4,   2, 2, 2,   0, 58, 56};
    vecs[3] = '{2,   0, 0, 0,   6, 4, 3,   0, 54, 52};
    vecs[4] = '{3, 255, 0, 1,   0, 0, 6,   0, 58, 52};
    vecs[5] = '{1,   3, 2, 5,   0, 0, 0,   1, 54, 52};

    reset = 1'b1; start = 1'b1;
    spr_en = '0; spr_x = '0; spr_y = '0; spr_colour = '0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d busy", i), int'(busy), 0);
      chk($sformatf("rst%0d done", i), int'(done), 0);
      chk($sformatf("rst%0d plot", i), int'(plot), 0);
      chk($sformatf("rst%0d xy", i), int'({x, y}), 0);
      chk($sformatf("rst%0d colour", i), int'(colour), 0);
      chk($sformatf("rst%0d mem_addr", i), int'(mem_addr), 0);
    end
    reset = 1'b0;
    tick();
    chk("rst_release busy", int'(busy), 1);
    start = 1'b0;
    got = -1;
    for (int e = 1; e <= 80; e++) begin
      tick();
      if (done && got < 0) got = e;
    end
    chk("rst_frame done_edge", got, 50);

    for (int vi = 0; vi < 6; vi++) begin
      run_frame(vi, vecs[vi]);
      if (vi == 2) begin
        chk("prio hits22_count", hits22.size(), 3);
        if (hits22.size() == 3) begin
          chk("prio first_sprite_colour", hits22[1], 4);
          chk("prio last_colour", hits22[2], 2);
        end
      end
    end

    // Abort: reset during the sprite pixel window
    spr_en = 2'b01; spr_x = '0; spr_y = '0; spr_colour = 6'o07;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 50; e++) tick();
    chk("abort pre plot", int'(plot), 1);
    chk("abort pre colour", int'(colour), 7);
    reset = 1'b1;
    tick();
    chk("abort plot", int'(plot), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort mem_addr", int'(mem_addr), 0);
    reset = 1'b0;
    got = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (done || busy) got++;
    end
    chk("abort no_done_busy_after", got, 0);

    // Back-to-back: start held high through the DONE cycle
    spr_en = 2'b00;
    start = 1'b1;
    tick();
    for (int e = 1; e <= 50; e++) tick();
    chk("b2b done_first", int'(done), 1);
    chk("b2b busy_in_done", int'(busy), 0);
    tick();
    chk("b2b busy_restart", int'(busy), 1);
    chk("b2b done_cleared", int'(done), 0);
    start = 1'b0;
    got = -1;
    for (int e = 52; e <= 130; e++) begin
      tick();
      if (e == 53) begin
        chk("b2b first_plot", int'(plot), 1);
        chk("b2b first_xy", int'({x, y}), {8'd20, 8'd10});
      end
      if (done && got < 0) got = e;
    end
    chk("b2b second_done_edge", got, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
